// File: rtl/fixed_point_seq_divider_if.sv
// Start/busy/valid handshake and operand/result bus for the divider.
// Carries signed_op only when SIGNED_DIV_EN is defined.
interface fixed_point_seq_divider_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             valid;
  logic             dvz;
  logic             ovf;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
`ifdef SIGNED_DIV_EN
  logic             signed_op;

  modport master (
    output start, a, b, signed_op,
    input  busy, valid, dvz, ovf, q, r
  );

  modport slave (
    input  start, a, b, signed_op,
    output busy, valid, dvz, ovf, q, r
  );
`else
  modport master (
    output start, a, b,
    input  busy, valid, dvz, ovf, q, r
  );

  modport slave (
    input  start, a, b,
    output busy, valid, dvz, ovf, q, r
  );
`endif
endinterface

// File: rtl/fixed_point_seq_divider.sv
// Sequential restoring divider for unsigned QI.F operands, one bit/clk.
// Define SIGNED_DIV_EN for optional two's complement operation.
module fixed_point_seq_divider #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 5
) (
  input logic                     clk,
  input logic                     rst,
  fixed_point_seq_divider_if.slave bus
);
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] FRAC_C = CW'(FRAC);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N-1:0]     d_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dvz_q;
  logic             ovf_q;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   p_diff;
  logic [WIDTH-1:0] p_nxt;
  logic [N-1:0]     d_nxt;
  logic             qbit;
  logic             abort;
  logic             last;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             ovf_fin;

`ifdef SIGNED_DIV_EN
  localparam logic [WIDTH-1:0] HALF =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic neg_a;
  logic neg_b;
  logic sop_q;
  logic qneg_q;
  logic rneg_q;

  assign neg_a = bus.signed_op & bus.a[WIDTH-1];
  assign neg_b = bus.signed_op & bus.b[WIDTH-1];
  assign a_mag = neg_a ? -bus.a : bus.a;
  assign b_mag = neg_b ? -bus.b : bus.b;
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  // Stored remainder stays below B, so only the shifted value needs
  // the extra bit; its borrow after subtracting B is the inverted qbit.
  always_comb begin
    p_sh   = {p_q, d_q[N-1]};
    p_diff = p_sh - {1'b0, b_q};
    qbit   = ~p_diff[WIDTH];
    p_nxt  = qbit ? p_diff[WIDTH-1:0] : p_sh[WIDTH-1:0];
    d_nxt  = {d_q[N-2:0], qbit};
    abort  = (cnt < FRAC_C) && qbit;
    last   = (cnt == LAST_C);
  end

  always_comb begin
    q_fin   = d_nxt[WIDTH-1:0];
    r_fin   = p_nxt;
    ovf_fin = 1'b0;
`ifdef SIGNED_DIV_EN
    if (sop_q) begin
      if (qneg_q ? (q_fin > HALF) : (q_fin >= HALF)) begin
        ovf_fin = 1'b1;
        q_fin   = '0;
        r_fin   = '0;
      end else begin
        if (qneg_q) q_fin = -q_fin;
        if (rneg_q) r_fin = -r_fin;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = (bus.b == '0) ? DONE : ITER;
      ITER:    if (abort || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != IDLE);
    bus.valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q   <= '0;
      p_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dvz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          d_q   <= N'(a_mag) << FRAC;
          b_q   <= b_mag;
          p_q   <= '0;
          cnt   <= '0;
          q_q   <= '0;
          r_q   <= '0;
          ovf_q <= 1'b0;
          dvz_q <= (bus.b == '0);
        end
        ITER: begin
          d_q <= d_nxt;
          p_q <= p_nxt;
          cnt <= cnt + CW'(1);
          if (abort) begin
            ovf_q <= 1'b1;
          end else if (last) begin
            q_q   <= q_fin;
            r_q   <= r_fin;
            ovf_q <= ovf_fin;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SIGNED_DIV_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sop_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (state == LOAD) begin
      sop_q  <= bus.signed_op;
      qneg_q <= neg_a ^ neg_b;
      rneg_q <= neg_a;
    end
  end
`endif

  assign bus.q   = q_q;
  assign bus.r   = r_q;
  assign bus.dvz = dvz_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_fixed_point_seq_divider.sv
// Scoreboard bench: driver pushes model results, monitor checks on valid.
// Signed cases are exercised only when SIGNED_DIV_EN is defined.
module tb_fixed_point_seq_divider;
  localparam int W = 8;
  localparam int F = 4;
  localparam int N = W + F;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dvz;
    logic         ovf;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fixed_point_seq_divider_if #(.WIDTH(W)) bus ();

  fixed_point_seq_divider #(
    .WIDTH(W),
    .FRAC (F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  // Quotient of the scaled dividend by the divisor, from plain arithmetic.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic sop, int c);
    exp_t e;
    int unsigned am, bm, full, rem;
    int msb;
    bit na, nb, neg;
    na = sop && a[W-1];
    nb = sop && b[W-1];
    neg = na ^ nb;
    am = na ? (32'd1 << W) - a : a;
    bm = nb ? (32'd1 << W) - b : b;
    e.q = '0;
    e.r = '0;
    e.dvz = 1'b0;
    e.ovf = 1'b0;
    if (bm == 0) begin
      e.dvz = 1'b1;
      e.due = c + 2;
      return e;
    end
    full = (am << F) / bm;
    rem  = (am << F) % bm;
    if (full >= (32'd1 << W)) begin
      msb = 0;
      for (int i = 0; i < N; i++)
        if ((full >> i) & 1) msb = i;
      e.ovf = 1'b1;
      e.due = c + (N - 1 - msb) + 3;
      return e;
    end
    e.due = c + N + 2;
    if (sop && (neg ? full > (32'd1 << (W - 1))
                    : full >= (32'd1 << (W - 1)))) begin
      e.ovf = 1'b1;
    end else begin
      e.q = W'(neg ? (32'd1 << W) - full : full);
      e.r = W'(na ? (32'd1 << W) - rem : rem);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.valid) begin
      if (sb.size() == 0) begin
        flag_fail("unexpected valid");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("q", bus.q, e.q);
        check("r", bus.r, e.r);
        check("dvz", bus.dvz, e.dvz);
        check("ovf", bus.ovf, e.ovf);
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) flag_fail("idle timeout");
  endtask

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b,
                       logic sop);
    wait_idle();
    bus.a = a;
    bus.b = b;
`ifdef SIGNED_DIV_EN
    bus.signed_op = sop;
`endif
    bus.start = 1'b1;
    sb.push_back(model(a, b, sop, cyc));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int c;
    int n;
    logic [W-1:0] ra, rb;
    logic rs;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SIGNED_DIV_EN
    bus.signed_op = 1'b0;
`endif
    #12;
    check("rst busy", bus.busy, 0);
    check("rst valid", bus.valid, 0);
    check("rst dvz", bus.dvz, 0);
    check("rst ovf", bus.ovf, 0);
    check("rst q", bus.q, 0);
    check("rst r", bus.r, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    issue(8'h30, 8'h20, 1'b0);
    issue(8'h30, 8'h00, 1'b0);
    check("dvz busy load", bus.busy, 1);
    @(negedge clk);
    check("dvz busy done", bus.busy, 1);
    @(negedge clk);
    check("dvz busy idle", bus.busy, 0);
    issue(8'hF0, 8'h01, 1'b0);
    issue(8'hFF, 8'h10, 1'b0);

    issue(8'h30, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    bus.a = 8'h11;
    bus.b = 8'h03;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    issue(8'h48, 8'h18, 1'b0);
    issue(8'h07, 8'h30, 1'b0);

    wait_idle();
    c = cyc;
    bus.a = 8'h30;
    bus.b = 8'h20;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < c + 6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid rst busy", bus.busy, 0);
    check("mid rst valid", bus.valid, 0);
    check("mid rst dvz", bus.dvz, 0);
    check("mid rst ovf", bus.ovf, 0);
    check("mid rst q", bus.q, 0);
    check("mid rst r", bus.r, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post rst busy", bus.busy, 0);
    issue(8'h30, 8'h20, 1'b0);

`ifdef SIGNED_DIV_EN
    issue(8'hD0, 8'h20, 1'b1);
    issue(8'h80, 8'hF0, 1'b1);
    issue(8'hD0, 8'h20, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255) >> $urandom_range(0, 7));
      rs = 1'b0;
`ifdef SIGNED_DIV_EN
      rs = 1'($urandom_range(0, 1));
`endif
      issue(ra, rb, rs);
    end

    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) flag_fail("drain timeout");
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
